// File: rtl/barrett_reduce_pipe_pkg.sv
// barrett_reduce_pipe_pkg: shared defaults and helpers for the Barrett reduction pipeline
package barrett_reduce_pipe_pkg;
  localparam int DEF_W = 64;
  localparam int N_STAGES = 4;
  function automatic int k_width(input int w);
    return $clog2(2 * w + 1);
  endfunction
endpackage

// File: rtl/barrett_reduce_pipe_if.sv
// barrett_reduce_pipe_if: config, input and output handshake bundle
interface barrett_reduce_pipe_if
  import barrett_reduce_pipe_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int MU_W = W + 1,
  parameter int K_W = k_width(W)
);
  logic            cfg_load;
  logic [W-1:0]    cfg_q;
  logic [MU_W-1:0] cfg_mu;
  logic [K_W-1:0]  cfg_k;
  logic            cfg_ack;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  in_z;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_t;
  logic            out_err;
  logic            busy;
  modport master (
    output cfg_load, cfg_q, cfg_mu, cfg_k, in_valid, in_z, out_ready,
    input  cfg_ack, in_ready, out_valid, out_t, out_err, busy
  );
  modport slave (
    input  cfg_load, cfg_q, cfg_mu, cfg_k, in_valid, in_z, out_ready,
    output cfg_ack, in_ready, out_valid, out_t, out_err, busy
  );
endinterface

// File: rtl/barrett_reduce_pipe_mod_correct.sv
// mod_correct: two conditional subtractions of q bringing t0 into [0, q)
module mod_correct #(
  parameter int W = 64,
  parameter int L = 3 * W + 1
) (
  input  logic [L-1:0] t0,
  input  logic [L-1:0] q,
  output logic [W-1:0] t,
  output logic         err
);
  logic [L-1:0] t1, t2;
  always_comb begin
    t1 = t0 >= q ? t0 - q : t0;
    t2 = t1 >= q ? t1 - q : t1;
    t = t2[W-1:0];
    err = t2 >= q;
  end
endmodule

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: 4-stage Barrett reduction z mod q with valid/ready handshake
module barrett_reduce_pipe
  import barrett_reduce_pipe_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int MU_W = W + 1,
  parameter int K_W = k_width(W)
) (
  input logic clk,
  input logic rst,
  barrett_reduce_pipe_if.slave bus
);
  localparam int L = 2 * W + MU_W;
  logic [W-1:0]          q_q, q_d;
  logic [MU_W-1:0]       mu_q, mu_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  ack_q, ack_d;
  logic [N_STAGES-1:0]   v_q, v_d;
  logic [2*W-1:0]        z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
  logic [L-1:0]          m1_q, m1_d, m2_q, m2_d, p_q, p_d;
  logic [W-1:0]          t_q, t_d, t_c;
  logic                  err_q, err_d, err_c;
  logic [L-1:0]          t0;
  logic                  stall, accept;
  mod_correct #(.W(W), .L(L)) u_corr (.t0(t0), .q(L'(q_q)), .t(t_c), .err(err_c));
  always_comb begin
    stall = v_q[N_STAGES-1] & ~bus.out_ready;
    accept = bus.cfg_load & ~bus.in_valid & ~|v_q;
    q_d = accept ? bus.cfg_q : q_q;
    mu_d = accept ? bus.cfg_mu : mu_q;
    k_d = accept ? bus.cfg_k : k_q;
    ack_d = accept;
    t0 = L'(z3_q) - p_q;
    v_d = stall ? v_q : {v_q[N_STAGES-2:0], bus.in_valid};
    z1_d = stall ? z1_q : bus.in_z;
    m1_d = stall ? m1_q : L'(bus.in_z) >> k_q;
    z2_d = stall ? z2_q : z1_q;
    m2_d = stall ? m2_q : m1_q * L'(mu_q);
    z3_d = stall ? z3_q : z2_q;
    p_d = stall ? p_q : (m2_q >> k_q) * L'(q_q);
    t_d = stall ? t_q : t_c;
    err_d = stall ? err_q : err_c;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      mu_q <= '0;
      k_q <= '0;
      ack_q <= 1'b0;
      v_q <= '0;
      z1_q <= '0;
      z2_q <= '0;
      z3_q <= '0;
      m1_q <= '0;
      m2_q <= '0;
      p_q <= '0;
      t_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q <= q_d;
      mu_q <= mu_d;
      k_q <= k_d;
      ack_q <= ack_d;
      v_q <= v_d;
      z1_q <= z1_d;
      z2_q <= z2_d;
      z3_q <= z3_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      p_q <= p_d;
      t_q <= t_d;
      err_q <= err_d;
    end
  end
  assign bus.in_ready = ~rst & ~stall;
  assign bus.out_valid = v_q[N_STAGES-1];
  assign bus.out_t = t_q;
  assign bus.out_err = err_q;
  assign bus.cfg_ack = ack_q;
  assign bus.busy = |v_q;
endmodule
